// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared encodings for the up/down counter and its prescaler, plus a
//   constant clog2 helper used to size the prescaler register.
//   DIR_DOWN/DIR_UP   : encodings of the 'up' input
//   MODE_WRAP/MODE_SAT: encodings of the 'sat' input
//   clog2(value)      : ceil(log2(value)), 0 for value <= 1
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2(input longint unsigned value);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((longint'(1) << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides enabled cycles by PRESCALE: 'tick' is high on the enabled cycle
//   that completes a group of PRESCALE enabled cycles.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset, zeroes the phase count
//   en   : advance the phase count (holds while low)
//   clr  : synchronous clear of the phase count (restart a full period)
//   tick : combinational, en && phase == PRESCALE-1
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // At least one bit so PRESCALE=1 still has a legal (constant-zero) register.
    localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Modulo-MODULUS up/down counter with wrap or saturate boundary handling,
//   a PRESCALE enabled-cycle divider, synchronous load and a sticky
//   boundary flag.
//   clk      : clock, rising edge
//   rstn     : synchronous active-low reset
//   en       : count enable (gates prescaler and step)
//   up       : 1 = increment, 0 = decrement
//   sat      : 1 = saturate at boundary, 0 = wrap
//   load     : synchronous load strobe (beats a step, restarts prescaler)
//   load_val : load value, clamped to MODULUS-1
//   ovf_clr  : clears ovf (a same-cycle boundary event wins)
//   q        : registered count, always within 0..MODULUS-1
//   tc       : one-cycle pulse in the cycle after each boundary event
//   ovf      : sticky boundary-event flag
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = 8,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("param_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("param_updown_counter: PRESCALE must be 1..65535");
    end

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

    // Load restarts the prescale period so the next step is a full period away.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .clr  (load),
        .tick (step)
    );

    always_comb begin
        q_d      = q_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q & ~ovf_clr;
        boundary = 1'b0;
        if (load) begin
            q_d = (load_val > QMAX) ? QMAX : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                if (q_q == QMAX) begin
                    boundary = 1'b1;
                    q_d      = (sat == MODE_SAT) ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    boundary = 1'b1;
                    q_d      = (sat == MODE_SAT) ? q_q : QMAX;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
        // Set beats a same-cycle clear.
        if (boundary) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    localparam int M  = 6;
    localparam int P1 = 1;
    localparam int P3 = 3;

    logic       clk = 1'b0;
    logic       rstn, en, up, sat, load, ovf_clr;
    logic [2:0] load_val;
    logic [2:0] q1, q3;
    logic       tc1, tc3, ovf1, ovf3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(3), .MODULUS(M), .PRESCALE(P1)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q1), .tc(tc1), .ovf(ovf1)
    );

    param_updown_counter #(.WIDTH(3), .MODULUS(M), .PRESCALE(P3)) dut3 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .q(q3), .tc(tc3), .ovf(ovf3)
    );

    // Reference model: count value, number of enabled cycles since the last
    // step, and the two flags, advanced once per rising edge.
    typedef struct {
        int q;
        int pre;
        bit tc;
        bit ovf;
    } mstate_t;

    mstate_t m1, m3;
    bit      mvalid = 1'b0;

    function automatic mstate_t model_next(mstate_t s, int modulus, int prescale);
        mstate_t n;
        bit      hit;
        n   = s;
        hit = 1'b0;
        if (!rstn) begin
            n.q = 0; n.pre = 0; n.tc = 1'b0; n.ovf = 1'b0;
        end else begin
            n.tc = 1'b0;
            if (ovf_clr) n.ovf = 1'b0;
            if (load) begin
                n.q   = (int'(load_val) >= modulus) ? modulus - 1 : int'(load_val);
                n.pre = 0;
            end else if (en) begin
                if (s.pre + 1 == prescale) begin
                    n.pre = 0;
                    if (up) begin
                        if (s.q == modulus - 1) begin
                            hit = 1'b1;
                            n.q = sat ? s.q : 0;
                        end else n.q = s.q + 1;
                    end else begin
                        if (s.q == 0) begin
                            hit = 1'b1;
                            n.q = sat ? s.q : modulus - 1;
                        end else n.q = s.q - 1;
                    end
                end else begin
                    n.pre = s.pre + 1;
                end
            end
            if (hit) begin
                n.tc  = 1'b1;
                n.ovf = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 = model_next(m1, M, P1);
        m3 = model_next(m3, M, P3);
        if (!rstn) mvalid = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("q1",   int'(q1),   m1.q);
            chk("tc1",  int'(tc1),  int'(m1.tc));
            chk("ovf1", int'(ovf1), int'(m1.ovf));
            chk("q3",   int'(q3),   m3.q);
            chk("tc3",  int'(tc3),  int'(m3.tc));
            chk("ovf3", int'(ovf3), int'(m3.ovf));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd3; ovf_clr = 1'b0;
        up = 1'b1; sat = 1'b0;
        cyc(); cyc();
        rstn = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    int exp_up[6] = '{1, 2, 3, 4, 5, 0};

    initial begin
        rstn = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
        load_val = '0; ovf_clr = 1'b0;
        cyc();

        // Reset state.
        do_reset();
        chk("rst_q", int'(q1), 0);
        chk("rst_tc", int'(tc1), 0);
        chk("rst_ovf", int'(ovf1), 0);

        // Wrap counting up: 1,2,3,4,5,0 with tc after 5->0.
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("up_q", int'(q1), exp_up[i]);
            chk("up_tc", int'(tc1), (i == 5) ? 1 : 0);
        end
        cyc();
        chk("up_tc_after", int'(tc1), 0);
        chk("up_ovf_sticky", int'(ovf1), 1);

        // Wrap counting down from reset: 0 -> 5 -> 4.
        do_reset();
        en = 1'b1; up = 1'b0;
        cyc();
        chk("dn_q5", int'(q1), 5);
        chk("dn_tc", int'(tc1), 1);
        cyc();
        chk("dn_q4", int'(q1), 4);
        chk("dn_tc_off", int'(tc1), 0);

        // Saturation at the top with ovf_clr racing a boundary event.
        load = 1'b1; load_val = 3'd5; ovf_clr = 1'b1; up = 1'b1; sat = 1'b1; en = 1'b1;
        cyc();
        chk("sat_load_q", int'(q1), 5);
        chk("sat_load_ovf", int'(ovf1), 0);
        chk("sat_load_tc", int'(tc1), 0);
        load = 1'b0; ovf_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ovf_clr = (i == 1);
            cyc();
            chk("sat_q", int'(q1), 5);
            chk("sat_tc", int'(tc1), 1);
            chk("sat_ovf", int'(ovf1), 1);
        end
        ovf_clr = 1'b0; en = 1'b0;
        cyc();
        chk("sat_tc_end", int'(tc1), 0);

        // Clamp on load, and load beating a step.
        load = 1'b1; load_val = 3'd7;
        cyc();
        chk("clamp_q", int'(q1), 5);
        sat = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 3'd2;
        cyc();
        chk("ldwin_q", int'(q1), 2);
        chk("ldwin_tc", int'(tc1), 0);
        load = 1'b0; en = 1'b0;

        // PRESCALE=3 with en gaps; a mid-period load restarts the period.
        do_reset();
        up = 1'b1; sat = 1'b0;
        en = 1'b1; cyc(); chk("ps_a", int'(q3), 0);
        en = 1'b1; cyc(); chk("ps_b", int'(q3), 0);
        en = 1'b0; cyc(); chk("ps_c", int'(q3), 0);
        en = 1'b1; cyc(); chk("ps_d", int'(q3), 1);
        en = 1'b1; cyc(); chk("ps_e", int'(q3), 1);
        load = 1'b1; load_val = 3'd2; cyc(); chk("ps_load", int'(q3), 2);
        load = 1'b0;
        cyc(); chk("ps_f", int'(q3), 2);
        cyc(); chk("ps_g", int'(q3), 2);
        cyc(); chk("ps_h", int'(q3), 3);

        // Reset mid-prescale at q=4 with ovf set.
        load = 1'b1; load_val = 3'd0; cyc();
        load = 1'b0; up = 1'b0; en = 1'b1;
        cyc(); cyc(); cyc();
        chk("pre_rst_q", int'(q3), 5);
        chk("pre_rst_ovf", int'(ovf3), 1);
        up = 1'b1; load = 1'b1; load_val = 3'd4; cyc();
        load = 1'b0; en = 1'b1; cyc();
        chk("mid_q4", int'(q3), 4);
        rstn = 1'b0; cyc();
        chk("mid_rst_q", int'(q3), 0);
        chk("mid_rst_tc", int'(tc3), 0);
        chk("mid_rst_ovf", int'(ovf3), 0);
        rstn = 1'b1; en = 1'b1;
        cyc(); cyc();
        chk("resume_q0", int'(q3), 0);
        cyc();
        chk("resume_q1", int'(q3), 1);

        // Randomized phase checked by the continuous compare process.
        for (int i = 0; i < 3000; i++) begin
            rstn     = ($urandom_range(63) != 0);
            load     = ($urandom_range(15) == 0);
            en       = ($urandom_range(3) != 0);
            ovf_clr  = ($urandom_range(7) == 0);
            up       = ($urandom_range(4) != 0) ? up : ~up;
            sat      = ($urandom_range(9) != 0) ? sat : ~sat;
            load_val = 3'($urandom_range(7));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, the counter width in bits (1..32).
REQ-002 The block SHALL have parameter MODULUS, default 8, the count range 0..MODULUS-1, legal 2..2^WIDTH.
REQ-003 The block SHALL have parameter PRESCALE, default 1, the number of enabled cycles per count step (1..65535).
REQ-004 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1, the reset: synchronous, active-low.
REQ-006 The block SHALL have port en, input, 1, the count enable; it gates the prescaler and the step.
REQ-007 The block SHALL have port up, input, 1, the direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port sat, input, 1, the boundary mode: 1 = saturate, 0 = wrap.
REQ-009 The block SHALL have port load, input, 1, the synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH, the load value.
REQ-011 The block SHALL have port ovf_clr, input, 1, which clears the sticky overflow flag.
REQ-012 The block SHALL have port q, output, WIDTH, the registered count.
REQ-013 The block SHALL have port tc, output, 1, the registered one-cycle terminal-count pulse.
REQ-014 The block SHALL have port ovf, output, 1, the sticky boundary-event flag.

Function
REQ-015 Priority SHALL be: rstn low, then load, then step; each is evaluated at every rising clk edge.
REQ-016 A step SHALL occur on a cycle where en=1 and the prescaler count equals PRESCALE-1; the prescaler then returns to 0; with PRESCALE=1 every enabled cycle is a step.
REQ-017 The prescaler SHALL advance only when en=1 and SHALL hold its value while en=0.
REQ-018 On a step with up=1 and q<MODULUS-1, q SHALL increment; with up=0 and q>0, q SHALL decrement.
REQ-019 A boundary event SHALL be a step with up=1 at q=MODULUS-1, or a step with up=0 at q=0.
REQ-020 On a boundary event with sat=0, q SHALL wrap: to 0 when counting up, to MODULUS-1 when counting down.
REQ-021 On a boundary event with sat=1, q SHALL hold its value.
REQ-022 tc SHALL be 1 for exactly the one cycle following each boundary event, in either mode, and 0 otherwise; consecutive saturated steps SHALL produce consecutive tc pulses.
REQ-023 ovf SHALL set on any boundary event and clear on ovf_clr=1; if both occur in the same cycle, set SHALL win.
REQ-024 A load SHALL take effect on the same edge: q=load_val, clamped to MODULUS-1 if load_val>=MODULUS; the prescaler SHALL be zeroed; no step occurs and tc SHALL be 0 the next cycle.
REQ-025 A direction or sat change SHALL take effect on the next step; it SHALL NOT alter the prescaler phase.
REQ-026 All arithmetic SHALL be modulo-free comparisons on WIDTH bits; q SHALL never leave 0..MODULUS-1.

Reset
REQ-027 While rstn=0 at a rising edge: q=0, tc=0, ovf=0, prescaler=0; load and en SHALL be ignored.
REQ-028 Reset asserted mid-prescale SHALL discard the partial prescale count.

Structure
REQ-029 A shared package counter_pkg SHALL hold the direction encodings (DIR_DOWN=0, DIR_UP=1), the mode encodings (MODE_WRAP=0, MODE_SAT=1) and a clog2 function used for prescaler sizing.
REQ-030 The prescaler SHALL be the sub-module tick_prescaler (clk, rstn, en, clr, tick); the counter core SHALL remain in param_updown_counter.
REQ-031 Illegal parameter values (MODULUS>2^WIDTH or MODULUS<2, PRESCALE<1) SHALL fail elaboration.

Verification
REQ-032 WIDTH=3, MODULUS=6, PRESCALE=1, up=1, sat=0, en=1 from reset: q = 0,1,2,3,4,5,0; tc=1 only in the cycle after 5->0; ovf=1 thereafter.
REQ-033 Same config, up=0 from reset: q = 0->5->4; tc pulses once, in the cycle after 0->5.
REQ-034 sat=1, load_val=5, up=1, three steps: q holds 5; tc high for 3 consecutive cycles; ovf_clr pulsed in the same cycle as a boundary event leaves ovf=1.
REQ-035 PRESCALE=3, en toggles 1,1,0,1: q steps once, on the third enabled cycle; a load mid-prescale restarts the 3-cycle count.
REQ-036 load_val=7 with MODULUS=6: q=5; load and step in the same cycle: load wins, tc=0.
REQ-037 rstn=0 asserted for one cycle at q=4 with prescaler mid-count: next cycle q=0, tc=0, ovf=0; counting resumes a full PRESCALE later.
